// File: rtl/ser_ctrl_pkg.sv
// Shared types and constants for the serializer load controller.
// PRBS7 constants are only consumed when SER_LOAD_CTRL_PRBS_EN is defined.
package ser_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRIME,
      S_RUN
   } ser_ctrl_state_t;

   // x^7 + x^6 + 1: feedback taps on state bits 6 and 5
   localparam logic [6:0] PRBS7_POLY = 7'b110_0000;
   localparam logic [6:0] PRBS7_SEED = 7'h7F;

endpackage

// File: rtl/prbs7_gen.sv
// Parallel PRBS7 generator producing W fresh bits per advance (bit 0 generated first).
// Built only when SER_LOAD_CTRL_PRBS_EN is defined.
`ifdef SER_LOAD_CTRL_PRBS_EN
module prbs7_gen
   import ser_ctrl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         adv_i,
   output logic [W-1:0] word_o
);

   logic [6:0] lfsr_q;
   logic [6:0] lfsr_d;

   // Unroll W serial steps; word_o shows the bits the next advance consumes
   always_comb begin
      logic [6:0] s;
      logic       fb;
      s      = lfsr_q;
      word_o = '0;
      for (int i = 0; i < W; i++) begin
         fb        = ^(s & PRBS7_POLY);
         word_o[i] = fb;
         s         = {s[5:0], fb};
      end
      lfsr_d = s;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= PRBS7_SEED;
      end else if (clr_i) begin
         lfsr_q <= PRBS7_SEED;
      end else if (adv_i) begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule
`endif

// File: rtl/serializer_load_ctrl.sv
// Feeds one parallel word per INPUTS_NUM-cycle frame to a tree serializer, with idle-word fill on underrun.
// Define SER_LOAD_CTRL_PRBS_EN to fill underruns with PRBS7 data instead of the constant IDLE_WORD.
module serializer_load_ctrl
   import ser_ctrl_pkg::*;
#(
   parameter int                    INPUTS_NUM = 8,
   parameter int                    CNT_W      = $clog2(INPUTS_NUM),
   parameter logic [INPUTS_NUM-1:0] IDLE_WORD  = '0
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ENABLE,
   input  logic [INPUTS_NUM-1:0] DATA_I,
   input  logic                  VALID_I,
   output logic                  READY_O,
   output logic [INPUTS_NUM-1:0] PAR_OUT,
   output logic                  FRAME_O,
   output logic                  UNDERRUN_O,
   input  logic                  CLR_UNDERRUN
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INPUTS_NUM - 1);

   ser_ctrl_state_t       state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  hold_full_q, hold_full_d;
   logic [INPUTS_NUM-1:0] hold_q;
   logic [INPUTS_NUM-1:0] par_q, par_d;
   logic                  frame_q, frame_d;
   logic                  underrun_q, underrun_d;

   logic                  load_slot;
   logic                  ready;
   logic                  accept;
   logic                  underrun_set;
   logic [INPUTS_NUM-1:0] idle_word;

   assign load_slot = (state_q == S_RUN) && (cnt_q == CNT_MAX);
   assign ready     = ENABLE && (state_q != S_IDLE) && (!hold_full_q || load_slot);
   assign accept    = VALID_I && ready;

`ifdef SER_LOAD_CTRL_PRBS_EN
   prbs7_gen #(
      .W (INPUTS_NUM)
   ) u_prbs7_gen (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .clr_i  (state_q == S_IDLE),
      .adv_i  (underrun_set),
      .word_o (idle_word)
   );
`else
   assign idle_word = IDLE_WORD;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hold_full_d  = hold_full_q;
      par_d        = par_q;
      frame_d      = 1'b0;
      underrun_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d       = '0;
            hold_full_d = 1'b0;
            par_d       = IDLE_WORD;
            if (ENABLE) begin
               state_d = S_PRIME;
               cnt_d   = CNT_MAX;
            end
         end
         S_PRIME: begin
            // Counter parked on the load slot so the first RUN cycle loads
            cnt_d = CNT_MAX;
            if (!ENABLE) begin
               state_d     = S_IDLE;
               cnt_d       = '0;
               hold_full_d = 1'b0;
            end else begin
               if (accept) begin
                  hold_full_d = 1'b1;
               end
               if (hold_full_q) begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (load_slot) begin
               frame_d = 1'b1;
               if (!ENABLE) begin
                  par_d       = IDLE_WORD;
                  hold_full_d = 1'b0;
                  state_d     = S_IDLE;
                  cnt_d       = '0;
               end else if (hold_full_q) begin
                  par_d       = hold_q;
                  hold_full_d = accept;
               end else begin
                  par_d        = idle_word;
                  underrun_set = 1'b1;
                  hold_full_d  = accept;
               end
            end else if (accept) begin
               hold_full_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A new underrun outranks a concurrent clear
      if (underrun_set) begin
         underrun_d = 1'b1;
      end else if (CLR_UNDERRUN) begin
         underrun_d = 1'b0;
      end else begin
         underrun_d = underrun_q;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
         par_q       <= IDLE_WORD;
         frame_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
         par_q       <= par_d;
         frame_q     <= frame_d;
         underrun_q  <= underrun_d;
      end
   end

   // Hold data is qualified by hold_full_q, so it needs no reset
   always_ff @(posedge CLK) begin
      if (accept) begin
         hold_q <= DATA_I;
      end
   end

   assign READY_O    = ready;
   assign PAR_OUT    = par_q;
   assign FRAME_O    = frame_q;
   assign UNDERRUN_O = underrun_q;

endmodule

// File: tb/tb_serializer_load_ctrl.sv
// Directed bench for serializer_load_ctrl (INPUTS_NUM=8, IDLE_WORD=0).
// The PRBS scenario is included only when SER_LOAD_CTRL_PRBS_EN is defined.
module tb_serializer_load_ctrl;

   logic       CLK;
   logic       RESET;
   logic       ENABLE;
   logic [7:0] DATA_I;
   logic       VALID_I;
   logic       READY_O;
   logic [7:0] PAR_OUT;
   logic       FRAME_O;
   logic       UNDERRUN_O;
   logic       CLR_UNDERRUN;

   int checks = 0;
   int errors = 0;

   serializer_load_ctrl #(
      .INPUTS_NUM (8),
      .IDLE_WORD  (8'h00)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .ENABLE       (ENABLE),
      .DATA_I       (DATA_I),
      .VALID_I      (VALID_I),
      .READY_O      (READY_O),
      .PAR_OUT      (PAR_OUT),
      .FRAME_O      (FRAME_O),
      .UNDERRUN_O   (UNDERRUN_O),
      .CLR_UNDERRUN (CLR_UNDERRUN)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      ENABLE       = 1'b0;
      VALID_I      = 1'b0;
      DATA_I       = 8'h00;
      CLR_UNDERRUN = 1'b0;
      RESET        = 1'b1;
      step();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      ENABLE       = 1'b1;
      VALID_I      = 1'b1;
      DATA_I       = 8'hFF;
      CLR_UNDERRUN = 1'b0;
      RESET        = 1'b0;
      #2;
      RESET = 1'b1;
      #1;
      checks++; if (PAR_OUT !== 8'h00) begin errors++; $display("FAIL rst_par got=%h exp=%h", PAR_OUT, 8'h00); end
      checks++; if (READY_O !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", READY_O); end
      checks++; if (FRAME_O !== 1'b0) begin errors++; $display("FAIL rst_frame got=%b exp=0", FRAME_O); end
      checks++; if (UNDERRUN_O !== 1'b0) begin errors++; $display("FAIL rst_underrun got=%b exp=0", UNDERRUN_O); end
      do_reset();
   endtask

   task automatic test_single_word();
      int frames;
      do_reset();
      ENABLE = 1'b1;
      step();
      checks++; if (READY_O !== 1'b1) begin errors++; $display("FAIL t1_ready_prime got=%b exp=1", READY_O); end
      VALID_I = 1'b1;
      DATA_I  = 8'hA5;
      step();
      VALID_I = 1'b0;
      #1;
      checks++; if (READY_O !== 1'b0) begin errors++; $display("FAIL t1_ready_full got=%b exp=0", READY_O); end
      step();
      checks++; if (PAR_OUT !== 8'h00) begin errors++; $display("FAIL t1_par_early got=%h exp=%h", PAR_OUT, 8'h00); end
      step();
      checks++; if (PAR_OUT !== 8'hA5) begin errors++; $display("FAIL t1_par_load got=%h exp=%h", PAR_OUT, 8'hA5); end
      frames = int'(FRAME_O);
      for (int i = 0; i < 7; i++) begin
         step();
         frames += int'(FRAME_O);
      end
      checks++; if (frames != 1) begin errors++; $display("FAIL t1_frame_count got=%0d exp=1", frames); end
      checks++; if (PAR_OUT !== 8'hA5) begin errors++; $display("FAIL t1_par_hold got=%h exp=%h", PAR_OUT, 8'hA5); end
      checks++; if (UNDERRUN_O !== 1'b0) begin errors++; $display("FAIL t1_underrun_early got=%b exp=0", UNDERRUN_O); end
      step();
      checks++; if (PAR_OUT !== 8'h00) begin errors++; $display("FAIL t1_par_idle got=%h exp=%h", PAR_OUT, 8'h00); end
      checks++; if (UNDERRUN_O !== 1'b1) begin errors++; $display("FAIL t1_underrun got=%b exp=1", UNDERRUN_O); end
      checks++; if (FRAME_O !== 1'b1) begin errors++; $display("FAIL t1_frame_idle got=%b exp=1", FRAME_O); end
   endtask

   task automatic test_back_to_back();
      logic       acc;
      logic [7:0] exp_par;
      logic       exp_ready;
      logic       exp_frame;
      do_reset();
      ENABLE  = 1'b1;
      VALID_I = 1'b1;
      DATA_I  = 8'h01;
      for (int c = 1; c <= 36; c++) begin
         acc = VALID_I && READY_O;
         step();
         if (acc) DATA_I = DATA_I + 8'h01;
         exp_par   = (c < 4) ? 8'h00 : 8'((c - 4) / 8 + 1);
         exp_ready = (c == 1) || (c >= 3 && (c % 8) == 3);
         exp_frame = (c >= 4) && ((c - 4) % 8 == 0);
         checks++; if (PAR_OUT !== exp_par) begin errors++; $display("FAIL t2_par c=%0d got=%h exp=%h", c, PAR_OUT, exp_par); end
         checks++; if (READY_O !== exp_ready) begin errors++; $display("FAIL t2_ready c=%0d got=%b exp=%b", c, READY_O, exp_ready); end
         checks++; if (FRAME_O !== exp_frame) begin errors++; $display("FAIL t2_frame c=%0d got=%b exp=%b", c, FRAME_O, exp_frame); end
      end
      checks++; if (UNDERRUN_O !== 1'b0) begin errors++; $display("FAIL t2_underrun got=%b exp=0", UNDERRUN_O); end
      VALID_I = 1'b0;
   endtask

   task automatic test_disable();
      logic acc;
      do_reset();
      ENABLE  = 1'b1;
      VALID_I = 1'b1;
      DATA_I  = 8'h11;
      for (int c = 1; c <= 7; c++) begin
         acc = VALID_I && READY_O;
         step();
         if (acc) DATA_I = DATA_I + 8'h11;
      end
      checks++; if (PAR_OUT !== 8'h11) begin errors++; $display("FAIL t3_par_run got=%h exp=%h", PAR_OUT, 8'h11); end
      ENABLE  = 1'b0;
      VALID_I = 1'b0;
      #1;
      checks++; if (READY_O !== 1'b0) begin errors++; $display("FAIL t3_ready_off got=%b exp=0", READY_O); end
      repeat (4) step();
      checks++; if (PAR_OUT !== 8'h11) begin errors++; $display("FAIL t3_par_complete got=%h exp=%h", PAR_OUT, 8'h11); end
      step();
      checks++; if (PAR_OUT !== 8'h00) begin errors++; $display("FAIL t3_par_idle got=%h exp=%h", PAR_OUT, 8'h00); end
      checks++; if (UNDERRUN_O !== 1'b0) begin errors++; $display("FAIL t3_no_underrun got=%b exp=0", UNDERRUN_O); end
      ENABLE = 1'b1;
      step();
      checks++; if (READY_O !== 1'b1) begin errors++; $display("FAIL t3_reprime_ready got=%b exp=1", READY_O); end
      repeat (10) step();
      checks++; if (PAR_OUT !== 8'h00) begin errors++; $display("FAIL t3_hold_dropped got=%h exp=%h", PAR_OUT, 8'h00); end
      checks++; if (READY_O !== 1'b1) begin errors++; $display("FAIL t3_hold_empty got=%b exp=1", READY_O); end
   endtask

   task automatic test_async_reset();
      do_reset();
      ENABLE = 1'b1;
      step();
      VALID_I = 1'b1;
      DATA_I  = 8'h5A;
      step();
      VALID_I = 1'b0;
      repeat (10) step();
      checks++; if (READY_O !== 1'b1) begin errors++; $display("FAIL t4_ready_slot0 got=%b exp=1", READY_O); end
      VALID_I = 1'b1;
      DATA_I  = 8'h3C;
      step();
      VALID_I = 1'b0;
      repeat (7) step();
      checks++; if (PAR_OUT !== 8'h3C) begin errors++; $display("FAIL t4_par_pre got=%h exp=%h", PAR_OUT, 8'h3C); end
      checks++; if (UNDERRUN_O !== 1'b1) begin errors++; $display("FAIL t4_underrun_pre got=%b exp=1", UNDERRUN_O); end
      checks++; if (FRAME_O !== 1'b1) begin errors++; $display("FAIL t4_frame_pre got=%b exp=1", FRAME_O); end
      RESET = 1'b1;
      #1;
      checks++; if (PAR_OUT !== 8'h00) begin errors++; $display("FAIL t4_par_async got=%h exp=%h", PAR_OUT, 8'h00); end
      checks++; if (FRAME_O !== 1'b0) begin errors++; $display("FAIL t4_frame_async got=%b exp=0", FRAME_O); end
      checks++; if (UNDERRUN_O !== 1'b0) begin errors++; $display("FAIL t4_underrun_async got=%b exp=0", UNDERRUN_O); end
      checks++; if (READY_O !== 1'b0) begin errors++; $display("FAIL t4_ready_async got=%b exp=0", READY_O); end
      step();
      RESET = 1'b0;
      step();
      checks++; if (READY_O !== 1'b1) begin errors++; $display("FAIL t4_restart_ready got=%b exp=1", READY_O); end
      VALID_I = 1'b1;
      DATA_I  = 8'h77;
      step();
      VALID_I = 1'b0;
      step();
      checks++; if (PAR_OUT !== 8'h00) begin errors++; $display("FAIL t4_restart_early got=%h exp=%h", PAR_OUT, 8'h00); end
      step();
      checks++; if (PAR_OUT !== 8'h77) begin errors++; $display("FAIL t4_restart_load got=%h exp=%h", PAR_OUT, 8'h77); end
   endtask

   task automatic test_underrun_clear();
      do_reset();
      ENABLE = 1'b1;
      step();
      VALID_I = 1'b1;
      DATA_I  = 8'h81;
      step();
      VALID_I = 1'b0;
      repeat (10) step();
      checks++; if (UNDERRUN_O !== 1'b1) begin errors++; $display("FAIL t5_underrun_set got=%b exp=1", UNDERRUN_O); end
      CLR_UNDERRUN = 1'b1;
      step();
      CLR_UNDERRUN = 1'b0;
      checks++; if (UNDERRUN_O !== 1'b0) begin errors++; $display("FAIL t5_clear got=%b exp=0", UNDERRUN_O); end
      repeat (6) step();
      CLR_UNDERRUN = 1'b1;
      step();
      CLR_UNDERRUN = 1'b0;
      checks++; if (UNDERRUN_O !== 1'b1) begin errors++; $display("FAIL t5_set_wins got=%b exp=1", UNDERRUN_O); end
      checks++; if (PAR_OUT !== 8'h00) begin errors++; $display("FAIL t5_par_idle got=%h exp=%h", PAR_OUT, 8'h00); end
      CLR_UNDERRUN = 1'b1;
      step();
      CLR_UNDERRUN = 1'b0;
      checks++; if (UNDERRUN_O !== 1'b0) begin errors++; $display("FAIL t5_clear_again got=%b exp=0", UNDERRUN_O); end
   endtask

`ifdef SER_LOAD_CTRL_PRBS_EN
   task automatic test_prbs();
      logic [6:0] lfsr;
      logic [7:0] exp_word;
      logic       fb;
      lfsr = 7'h7F;
      do_reset();
      ENABLE = 1'b1;
      step();
      VALID_I = 1'b1;
      DATA_I  = 8'hAA;
      step();
      VALID_I = 1'b0;
      step();
      step();
      checks++; if (PAR_OUT !== 8'hAA) begin errors++; $display("FAIL t6_par_data got=%h exp=%h", PAR_OUT, 8'hAA); end
      for (int w = 0; w < 4; w++) begin
         for (int j = 0; j < 8; j++) begin
            fb          = lfsr[6] ^ lfsr[5];
            exp_word[j] = fb;
            lfsr        = {lfsr[5:0], fb};
         end
         repeat (8) step();
         checks++; if (PAR_OUT !== exp_word) begin errors++; $display("FAIL t6_prbs w=%0d got=%h exp=%h", w, PAR_OUT, exp_word); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_disable();
      test_async_reset();
      test_underrun_clear();
`ifdef SER_LOAD_CTRL_PRBS_EN
      test_prbs();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
